// File: rtl/bram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_arbiter_pkg
// Description : Shared types and constants for the BRAM arbiter: requester
//               identifiers, the read-return tag carried through the latency
//               pipe, the BRAM geometry that sets the default address width,
//               and a helper that applies a per-port flush to a tag.
// Revision    : 1.0 - initial release
// ============================================================================
package bram_arbiter_pkg;

    // Requester identifiers carried in the read-return tag.
    typedef enum logic [1:0] {
        ARB_LD = 2'd0,
        ARB_DM = 2'd1,
        ARB_IM = 2'd2
    } arb_port_t;

    // BRAM depth in words; the default word-address width is derived from it.
    localparam int BRAM_SIZE   = 524288;
    localparam int BRAM_ADDR_W = $clog2(BRAM_SIZE);

    // One entry of the read-return pipe.
    typedef struct packed {
        logic      valid;
        arb_port_t port;
    } rd_tag_t;

    // Drops the valid bit of a tag owned by the flushed port.
    function automatic rd_tag_t tag_flush(input rd_tag_t   tag,
                                          input logic      flush,
                                          input arb_port_t port);
        rd_tag_t t;
        t = tag;
        if (flush && (tag.port == port)) begin
            t.valid = 1'b0;
        end
        return t;
    endfunction

endpackage : bram_arbiter_pkg
`default_nettype wire

// File: rtl/bram_rd_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : bram_rd_tag_pipe
// Description : RD_LAT-deep shift register of read-return tags. Each cycle a
//               new tag enters at the head; the tail tag lines up with the
//               BRAM read data of the access that produced it. A flush clears
//               the valid bit of every tag belonging to flush_port, including
//               the tag entering this cycle.
// Ports       : clk        - system clock
//               rstn       - synchronous active-low reset (clears all stages)
//               in_tag     - tag of this cycle's BRAM access
//               flush      - drop tags owned by flush_port
//               flush_port - requester whose tags are dropped
//               tail_tag   - tag whose read data is on the BRAM output now
// Revision    : 1.0 - initial release
// ============================================================================
module bram_rd_tag_pipe
    import bram_arbiter_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic      clk,
    input  logic      rstn,
    input  rd_tag_t   in_tag,
    input  logic      flush,
    input  arb_port_t flush_port,
    output rd_tag_t   tail_tag
);

    rd_tag_t r_stage [RD_LAT];
    rd_tag_t w_src   [RD_LAT];

    // Source of each stage: the new tag for the head, the previous stage
    // otherwise.
    always_comb begin
        w_src[0] = in_tag;
        for (int i = 1; i < RD_LAT; i++) begin
            w_src[i] = r_stage[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_stage[i] <= tag_flush(w_src[i], flush, flush_port);
            end
        end
    end

    // The tail is already returning its data this cycle, so a flush does not
    // retract it.
    assign tail_tag = r_stage[RD_LAT-1];

endmodule : bram_rd_tag_pipe
`default_nettype wire

// File: rtl/bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bram_arbiter
// Description : Shares one single-port BRAM between the program loader (LD),
//               execute-stage load/store (DM) and instruction fetch (IM).
//               Fixed priority LD > DM > IM, with IM promoted over DM after
//               STARVE_MAX consecutive denied cycles. Reads return after a
//               fixed RD_LAT cycles with a per-requester rvalid; im_flush
//               drops IM reads still in flight.
// Options     : define BRAM_ARB_PERF_EN to add the 32-bit performance counters
//               perf_gnt_ld/dm/im (accepted requests per port) and
//               perf_conflict (cycles with two or more requests).
// Ports       : clk, rstn           - clock, synchronous active-low reset
//               {ld,dm,im}_req      - request valid
//               {ld,dm}_we          - write enable (IM is read-only)
//               {ld,dm,im}_addr     - word address
//               {ld,dm}_wdata       - write data
//               {ld,dm,im}_gnt      - request accepted this cycle
//               {ld,dm,im}_rvalid   - read data valid on rdata
//               rdata               - returned read data (shared)
//               im_flush            - drop in-flight IM reads
//               mem_en/we/addr/wdata- BRAM request side
//               mem_rdata           - BRAM read data (RD_LAT after mem_en)
// Revision    : 1.0 - initial release
// ============================================================================
module bram_arbiter
    import bram_arbiter_pkg::*;
#(
    parameter int ADDR_W     = BRAM_ADDR_W,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ld_req,
    input  logic              dm_req,
    input  logic              im_req,
    input  logic              ld_we,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [ADDR_W-1:0] im_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              ld_gnt,
    output logic              dm_gnt,
    output logic              im_gnt,
    output logic              ld_rvalid,
    output logic              dm_rvalid,
    output logic              im_rvalid,
    output logic [DATA_W-1:0] rdata,
    input  logic              im_flush,
`ifdef BRAM_ARB_PERF_EN
    output logic [31:0]       perf_gnt_ld,
    output logic [31:0]       perf_gnt_dm,
    output logic [31:0]       perf_gnt_im,
    output logic [31:0]       perf_conflict,
`endif
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

    logic [3:0]        r_starve_cnt;
    logic              w_promote;
    logic              w_ld_gnt;
    logic              w_dm_gnt;
    logic              w_im_gnt;
    logic              w_any_gnt;

    arb_port_t         w_port;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [ADDR_W-1:0] r_addr_hold;
    logic [DATA_W-1:0] r_wdata_hold;

    rd_tag_t           w_in_tag;
    rd_tag_t           w_tail_tag;
    logic              w_tail_valid;
    logic [DATA_W-1:0] r_rdata;

    // ------------------------------------------------------------------
    // Arbitration. IM is promoted over DM (never over LD) once it has been
    // denied STARVE_MAX cycles in a row. Requests are ignored in reset.
    // ------------------------------------------------------------------
    assign w_promote = im_req && (r_starve_cnt == c_starve_max);
    assign w_ld_gnt  = rstn && ld_req;
    assign w_dm_gnt  = rstn && !ld_req && dm_req && !w_promote;
    assign w_im_gnt  = rstn && !ld_req && im_req && (!dm_req || w_promote);
    assign w_any_gnt = w_ld_gnt || w_dm_gnt || w_im_gnt;

    assign ld_gnt = w_ld_gnt;
    assign dm_gnt = w_dm_gnt;
    assign im_gnt = w_im_gnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_starve_cnt <= '0;
        end else if (!im_req || w_im_gnt) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != c_starve_max) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Winner mux onto the BRAM. When idle, address and write data keep
    // their previous value so the BRAM pins do not toggle needlessly.
    // ------------------------------------------------------------------
    always_comb begin
        w_port  = ARB_LD;
        w_we    = 1'b0;
        w_addr  = r_addr_hold;
        w_wdata = r_wdata_hold;
        if (w_ld_gnt) begin
            w_port  = ARB_LD;
            w_we    = ld_we;
            w_addr  = ld_addr;
            w_wdata = ld_wdata;
        end else if (w_dm_gnt) begin
            w_port  = ARB_DM;
            w_we    = dm_we;
            w_addr  = dm_addr;
            w_wdata = dm_wdata;
        end else if (w_im_gnt) begin
            w_port  = ARB_IM;
            w_addr  = im_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_addr_hold  <= '0;
            r_wdata_hold <= '0;
        end else begin
            r_addr_hold  <= w_addr;
            r_wdata_hold <= w_wdata;
        end
    end

    assign mem_en    = w_any_gnt;
    assign mem_we    = w_we;
    assign mem_addr  = w_addr;
    assign mem_wdata = w_wdata;

    // ------------------------------------------------------------------
    // Read return. Writes enter the pipe as invalid tags so every slot
    // stays aligned with the BRAM's fixed read latency.
    // ------------------------------------------------------------------
    assign w_in_tag.valid = w_any_gnt && !w_we;
    assign w_in_tag.port  = w_port;

    bram_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk        (clk),
        .rstn       (rstn),
        .in_tag     (w_in_tag),
        .flush      (im_flush),
        .flush_port (ARB_IM),
        .tail_tag   (w_tail_tag)
    );

    // Gated by rstn so a tag reaching the tail during reset never pulses.
    assign w_tail_valid = rstn && w_tail_tag.valid;

    assign ld_rvalid = w_tail_valid && (w_tail_tag.port == ARB_LD);
    assign dm_rvalid = w_tail_valid && (w_tail_tag.port == ARB_DM);
    assign im_rvalid = w_tail_valid && (w_tail_tag.port == ARB_IM);

    // rdata passes the BRAM output through in the return cycle and otherwise
    // shows the last returned word, which is cleared by reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rdata <= '0;
        end else if (w_tail_valid) begin
            r_rdata <= mem_rdata;
        end
    end

    assign rdata = w_tail_valid ? mem_rdata : r_rdata;

`ifdef BRAM_ARB_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters, wrapping modulo 2^32.
    // ------------------------------------------------------------------
    logic [31:0] r_perf_ld;
    logic [31:0] r_perf_dm;
    logic [31:0] r_perf_im;
    logic [31:0] r_perf_conflict;
    logic        w_conflict;

    assign w_conflict = (ld_req && dm_req) || (ld_req && im_req) || (dm_req && im_req);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_perf_ld       <= '0;
            r_perf_dm       <= '0;
            r_perf_im       <= '0;
            r_perf_conflict <= '0;
        end else begin
            if (w_ld_gnt) r_perf_ld <= r_perf_ld + 32'd1;
            if (w_dm_gnt) r_perf_dm <= r_perf_dm + 32'd1;
            if (w_im_gnt) r_perf_im <= r_perf_im + 32'd1;
            if (w_conflict) r_perf_conflict <= r_perf_conflict + 32'd1;
        end
    end

    assign perf_gnt_ld   = r_perf_ld;
    assign perf_gnt_dm   = r_perf_dm;
    assign perf_gnt_im   = r_perf_im;
    assign perf_conflict = r_perf_conflict;
`endif

endmodule : bram_arbiter
`default_nettype wire

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Shares the single-port data/instruction BRAM between three requesters:
  - program loader (LD), active during LOAD mode;
  - execute-stage load/store (DM);
  - instruction fetch (IM).
- Fixed-priority arbitration with a starvation guard for fetch.
- Fixed-latency read return, tagged per requester.
- Sits between the fetch/execute/loader units and the BRAM primitive.

Parameters:
- ADDR_W, 19, BRAM word-address width.
- DATA_W, 32, data width.
- RD_LAT, 2, BRAM read latency in cycles (1..4).
- STARVE_MAX, 4, consecutive denied IM cycles before IM is promoted over DM (1..15).

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset
- ld_req, dm_req, im_req  in  1 each  request valid
- ld_we, dm_we  in  1 each  1 = write (IM is read-only)
- ld_addr, dm_addr, im_addr  in  ADDR_W each  word address
- ld_wdata, dm_wdata  in  DATA_W each  write data
- ld_gnt, dm_gnt, im_gnt  out  1 each  request accepted this cycle
- ld_rvalid, dm_rvalid, im_rvalid  out  1 each  read data valid
- rdata  out  DATA_W  returned read data, shared by all ports
- im_flush  in  1  drop IM reads still in flight (branch redirect)
- mem_en  out  1  BRAM enable
- mem_we  out  1  BRAM write enable
- mem_addr  out  ADDR_W  BRAM address
- mem_wdata  out  DATA_W  BRAM write data
- mem_rdata  in  DATA_W  BRAM read data, valid RD_LAT cycles after mem_en

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rstn.
- Handshake:
  - A request is accepted in a cycle where req && gnt.
  - The requester holds req, we, addr and wdata stable until gnt.
  - Back-to-back accepted requests are allowed every cycle.
- gnt is combinational from the req inputs and the starvation state. At most one gnt is high per cycle.
- mem_* is driven combinationally from the winner in the same cycle.
- mem_en = any gnt. mem_we = winner's we; it is 0 when the winner is IM.
- Priority: LD > DM > IM.
  - Exception: when starve_cnt == STARVE_MAX and im_req=1, IM beats DM.
  - LD always wins.
- starve_cnt (4-bit):
  - Increments when im_req && !im_gnt, saturating at STARVE_MAX.
  - Clears on im_gnt or when im_req=0.
- Read return:
  - A tag pipeline RD_LAT deep carries {valid, port_id} for each granted read. Writes insert valid=0.
  - At the pipe tail, exactly one of *_rvalid pulses for 1 cycle per accepted read, in grant order. rdata = mem_rdata.
  - Each rvalid fires exactly RD_LAT cycles after its grant cycle.
- im_flush:
  - Clears valid on every in-flight tag with port_id=IM.
  - A grant to IM in the same cycle is also dropped; the BRAM access still occurs but returns no rvalid.
  - DM and LD entries are unaffected.
- Write data does not return. A read to the address written in the previous cycle returns the BRAM's native read-after-write result; the arbiter does not forward.
- Reset values:
  - All gnt = 0 while rstn=0; the req inputs are ignored during reset.
  - All rvalid = 0. rdata = 0 (registered mux).
  - mem_en = 0, mem_we = 0.
  - Tag pipe cleared. starve_cnt = 0.
- Reset mid-operation: in-flight reads are discarded. No rvalid is produced for them after reset is released.
- Idle (no req): mem_en = 0. mem_addr and mem_wdata hold their last value; they are don't-care.

Optional Feature:
- Macro: BRAM_ARB_PERF_EN.
- With the macro defined:
  - Adds outputs perf_gnt_ld, perf_gnt_dm, perf_gnt_im (32 bits each). Each counts accepted requests on its port.
  - Adds output perf_conflict (32 bits). It counts cycles with at least 2 reqs asserted.
  - All four counters are zeroed on reset and wrap modulo 2^32.
- Without the macro: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package constant:
  - typedef enum logic [1:0] arb_port_t {ARB_LD=0, ARB_DM=1, ARB_IM=2}.
  - BRAM_SIZE, used as the ADDR_W source.
  - Rd-tag struct {logic valid; arb_port_t port}.
- One sub-module, bram_rd_tag_pipe:
  - RD_LAT-deep shift register of tags.
  - Has a flush-by-port input.
  - Outputs the tail tag.
- Arbitration and the starvation counter stay in bram_arbiter.

Test Plan:
- LD write addr 0x10 data 0xDEADBEEF, then IM read addr 0x10 → ld_gnt on the first cycle, im_gnt on the next cycle, im_rvalid exactly 2 cycles after that im_gnt with rdata = 0xDEADBEEF; dm_rvalid and ld_rvalid stay 0.
- LD, DM and IM all requesting in the same cycle → ld_gnt only. The next cycle, with LD dropped, gives dm_gnt. IM is granted after DM deasserts.
- DM held continuously high for 10 cycles with im_req=1 → im_gnt in cycle 5, after 4 denials, then starve_cnt = 0 and DM resumes; IM wins again 4 denials later.
- DM read addr 3 (value 0x33), then IM read addr 4 (value 0x44) in consecutive cycles → dm_rvalid with 0x33, then im_rvalid with 0x44 on consecutive cycles, in order.
- IM read granted, then im_flush pulsed 1 cycle later → no im_rvalid. A DM read granted between the two still returns dm_rvalid.
- rstn=0 for 1 cycle while 2 reads are in flight → all rvalid stay 0 afterwards and starve_cnt = 0. With BRAM_ARB_PERF_EN defined, all perf counters read 0.
